// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot occupancy tracker.
// Holds the lot geometry, the hour boundaries of the day/ramp/shared
// windows, the 10-bit count type and the saturating vacancy helpers.
package parking_pkg;

  typedef logic [9:0] count_t;
  typedef logic [4:0] hour_t;

  localparam count_t TOTAL_SPACES = 10'd700;
  localparam count_t UNI_BASE     = 10'd500;
  localparam count_t STEP         = 10'd50;

  localparam hour_t DAY_START  = 5'd8;
  localparam hour_t RAMP_START = 5'd13;
  localparam hour_t DAY_END    = 5'd16;

  // Subtraction that floors at zero instead of wrapping.
  function automatic count_t satSub(input count_t a, input count_t b);
    return (a > b) ? count_t'(a - b) : '0;
  endfunction

  // Free spaces for one class: room left under the class capacity, but
  // never more than the room left in the whole lot. A capacity that has
  // shrunk below the current count yields zero rather than wrapping.
  function automatic count_t satVacancy(input count_t cap, input count_t own,
                                        input count_t other);
    logic [10:0] total;
    logic [10:0] lotLimit;
    count_t      classRoom;
    count_t      lotRoom;
    total     = {1'b0, own} + {1'b0, other};
    lotLimit  = {1'b0, TOTAL_SPACES};
    classRoom = satSub(cap, own);
    lotRoom   = (total < lotLimit) ? count_t'(lotLimit - total) : '0;
    return (classRoom < lotRoom) ? classRoom : lotRoom;
  endfunction

endpackage

// File: rtl/parking_capacity.sv
// Maps the hour of day to per-class capacities.
// Ports:
//   hour_i        in   5   hour of day (24..31 treated as shared window)
//   uniCount_i    in  10   university cars parked
//   nonuniCount_i in  10   non-university cars parked
//   uniCap_o      out 10   capacity available to university cars
//   nonuniCap_o   out 10   capacity available to non-university cars
module parking_capacity
  import parking_pkg::*;
(
  input  logic [4:0] hour_i,
  input  count_t     uniCount_i,
  input  count_t     nonuniCount_i,
  output count_t     uniCap_o,
  output count_t     nonuniCap_o
);

  // Day window is the default split. The ramp window hands STEP spaces per
  // hour from university to non-university. Outside both windows the lot is
  // shared, so each class may use whatever the other class leaves free.
  always_comb begin
    uniCap_o    = UNI_BASE;
    nonuniCap_o = TOTAL_SPACES - UNI_BASE;
    if (hour_i >= RAMP_START && hour_i < DAY_END) begin
      nonuniCap_o = (TOTAL_SPACES - UNI_BASE)
                  + STEP * count_t'(hour_i - (RAMP_START - 5'd1));
      uniCap_o    = TOTAL_SPACES - nonuniCap_o;
    end else if (hour_i < DAY_START || hour_i >= DAY_END) begin
      uniCap_o    = satSub(TOTAL_SPACES, nonuniCount_i);
      nonuniCap_o = satSub(TOTAL_SPACES, uniCount_i);
    end
  end

endmodule

// File: rtl/parking_system.sv
// Parking lot occupancy tracker for university and non-university cars.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   car_entered / car_exited   gate sensor levels, rising edge = one car
//   is_uni_car_entered/exited  class qualifier sampled with each edge
//   hour                       hour of day 0..23
//   uni_parked_car, parked_car per-class parked counts
//   uni_vacated_space, vacated_space  per-class free spaces
//   uni_is_vacated_space, is_vacated_space, parking_is_vacated_space  flags
module parking_system
  import parking_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_entered,
  input  logic       is_uni_car_entered,
  input  logic       car_exited,
  input  logic       is_uni_car_exited,
  input  logic [4:0] hour,
  output logic [9:0] uni_parked_car,
  output logic [9:0] parked_car,
  output logic [9:0] uni_vacated_space,
  output logic [9:0] vacated_space,
  output logic       uni_is_vacated_space,
  output logic       is_vacated_space,
  output logic       parking_is_vacated_space
);

  logic   entPrev_q;
  logic   extPrev_q;
  count_t uniCount_q, uniCount_d;
  count_t nonuniCount_q, nonuniCount_d;

  logic   entryEvt;
  logic   exitEvt;
  count_t uniPost, nonuniPost;
  count_t uniCap, nonuniCap;
  count_t uniCapPost, nonuniCapPost;
  count_t uniVacPost, nonuniVacPost;

  assign entryEvt = car_entered & ~entPrev_q;
  assign exitEvt  = car_exited & ~extPrev_q;

  // Capacity seen by the outputs, from the registered counts.
  parking_capacity u_capNow (
    .hour_i        (hour),
    .uniCount_i    (uniCount_q),
    .nonuniCount_i (nonuniCount_q),
    .uniCap_o      (uniCap),
    .nonuniCap_o   (nonuniCap)
  );

  // Capacity after this cycle's exit, used to admit a same-cycle entry.
  parking_capacity u_capPost (
    .hour_i        (hour),
    .uniCount_i    (uniPost),
    .nonuniCount_i (nonuniPost),
    .uniCap_o      (uniCapPost),
    .nonuniCap_o   (nonuniCapPost)
  );

  // Exit is applied first and never underflows an empty class.
  always_comb begin
    uniPost    = uniCount_q;
    nonuniPost = nonuniCount_q;
    if (exitEvt) begin
      if (is_uni_car_exited) begin
        if (uniCount_q != '0) uniPost = uniCount_q - 10'd1;
      end else begin
        if (nonuniCount_q != '0) nonuniPost = nonuniCount_q - 10'd1;
      end
    end
  end

  assign uniVacPost    = satVacancy(uniCapPost, uniPost, nonuniPost);
  assign nonuniVacPost = satVacancy(nonuniCapPost, nonuniPost, uniPost);

  // Entry is admitted only when the post-exit vacancy for its class is
  // non-zero; a refused car leaves the counts untouched.
  always_comb begin
    uniCount_d    = uniPost;
    nonuniCount_d = nonuniPost;
    if (entryEvt) begin
      if (is_uni_car_entered) begin
        if (uniVacPost != '0) uniCount_d = uniPost + 10'd1;
      end else begin
        if (nonuniVacPost != '0) nonuniCount_d = nonuniPost + 10'd1;
      end
    end
  end

  // Counters and sensor history; reset wins over any pending edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entPrev_q     <= 1'b0;
      extPrev_q     <= 1'b0;
      uniCount_q    <= '0;
      nonuniCount_q <= '0;
    end else begin
      entPrev_q     <= car_entered;
      extPrev_q     <= car_exited;
      uniCount_q    <= uniCount_d;
      nonuniCount_q <= nonuniCount_d;
    end
  end

  assign uni_parked_car           = uniCount_q;
  assign parked_car               = nonuniCount_q;
  assign uni_vacated_space        = satVacancy(uniCap, uniCount_q, nonuniCount_q);
  assign vacated_space            = satVacancy(nonuniCap, nonuniCount_q, uniCount_q);
  assign uni_is_vacated_space     = (uni_vacated_space != '0);
  assign is_vacated_space         = (vacated_space != '0);
  assign parking_is_vacated_space = ({1'b0, uniCount_q} + {1'b0, nonuniCount_q})
                                  < {1'b0, TOTAL_SPACES};

endmodule

// File: tb/tb_parking_system.sv
// Self-checking bench for parking_system: a behavioural model of the lot
// pushes expected outputs into a queue as each stimulus is driven, and the
// entries are popped and compared once the DUT has reacted.
module tb_parking_system;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic [4:0] hour;
  logic [9:0] uni_parked_car;
  logic [9:0] parked_car;
  logic [9:0] uni_vacated_space;
  logic [9:0] vacated_space;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic       parking_is_vacated_space;

  typedef struct {
    int uniPark;
    int park;
    int uniVac;
    int vac;
    int uFlag;
    int vFlag;
    int pFlag;
  } expect_t;

  expect_t expQ[$];
  int      mUni = 0;
  int      mNon = 0;
  int      checkCount = 0;
  int      passCount = 0;

  parking_system dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .car_entered              (car_entered),
    .is_uni_car_entered       (is_uni_car_entered),
    .car_exited               (car_exited),
    .is_uni_car_exited        (is_uni_car_exited),
    .hour                     (hour),
    .uni_parked_car           (uni_parked_car),
    .parked_car               (parked_car),
    .uni_vacated_space        (uni_vacated_space),
    .vacated_space            (vacated_space),
    .uni_is_vacated_space     (uni_is_vacated_space),
    .is_vacated_space         (is_vacated_space),
    .parking_is_vacated_space (parking_is_vacated_space)
  );

  always #5 clk = ~clk;

  // Guards against a run that never reaches its summary.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Reference vacancy from the hour windows, written with plain integers.
  function automatic void modelVacancy(output int uVac, output int nVac);
    int h;
    int uCap;
    int nCap;
    int lot;
    h = int'(hour);
    if (h >= 8 && h <= 12) begin
      uCap = 500;
      nCap = 200;
    end else if (h >= 13 && h <= 15) begin
      nCap = 200 + 50 * (h - 12);
      uCap = 700 - nCap;
    end else begin
      uCap = 700 - mNon;
      nCap = 700 - mUni;
    end
    lot  = 700 - mUni - mNon;
    uVac = uCap - mUni;
    nVac = nCap - mNon;
    if (uVac < 0) uVac = 0;
    if (nVac < 0) nVac = 0;
    if (uVac > lot) uVac = lot;
    if (nVac > lot) nVac = lot;
  endfunction

  // Model of one sensor cycle: exit first, then entry against the new vacancy.
  function automatic void modelStep(input bit ent, input bit uniEnt,
                                    input bit ext, input bit uniExt);
    int uv;
    int nv;
    if (ext) begin
      if (uniExt) begin
        if (mUni > 0) mUni--;
      end else if (mNon > 0) mNon--;
    end
    if (ent) begin
      modelVacancy(uv, nv);
      if (uniEnt) begin
        if (uv > 0) mUni++;
      end else if (nv > 0) mNon++;
    end
  endfunction

  function automatic void pushExpect();
    expect_t e;
    int      uv;
    int      nv;
    modelVacancy(uv, nv);
    e.uniPark = mUni;
    e.park    = mNon;
    e.uniVac  = uv;
    e.vac     = nv;
    e.uFlag   = (uv != 0) ? 1 : 0;
    e.vFlag   = (nv != 0) ? 1 : 0;
    e.pFlag   = (mUni + mNon < 700) ? 1 : 0;
    expQ.push_back(e);
  endfunction

  task automatic compareNext(input string tag);
    expect_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 0, 1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".uniPark"}, int'(uni_parked_car), e.uniPark);
      checkOutput({tag, ".park"}, int'(parked_car), e.park);
      checkOutput({tag, ".uniVac"}, int'(uni_vacated_space), e.uniVac);
      checkOutput({tag, ".vac"}, int'(vacated_space), e.vac);
      checkOutput({tag, ".uFlag"}, int'(uni_is_vacated_space), e.uFlag);
      checkOutput({tag, ".vFlag"}, int'(is_vacated_space), e.vFlag);
      checkOutput({tag, ".pFlag"}, int'(parking_is_vacated_space), e.pFlag);
    end
  endtask

  // One sensor pulse: raise the levels, let the DUT see the edge, compare,
  // then drop the levels so the next pulse is a fresh rising edge.
  task automatic applyStimulus(input string tag, input bit ent, input bit uniEnt,
                               input bit ext, input bit uniExt);
    @(negedge clk);
    car_entered        = ent;
    is_uni_car_entered = uniEnt;
    car_exited         = ext;
    is_uni_car_exited  = uniExt;
    modelStep(ent, uniEnt, ext, uniExt);
    pushExpect();
    @(posedge clk);
    #1;
    compareNext(tag);
    @(negedge clk);
    car_entered = 1'b0;
    car_exited  = 1'b0;
  endtask

  task automatic setHour(input int h);
    @(negedge clk);
    hour = 5'(h);
    #1;
    pushExpect();
    compareNext($sformatf("hour%0d", h));
  endtask

  initial begin
    rst_n              = 1'b0;
    car_entered        = 1'b0;
    is_uni_car_entered = 1'b0;
    car_exited         = 1'b0;
    is_uni_car_exited  = 1'b0;
    hour               = 5'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pushExpect();
    compareNext("reset");
    checkOutput("rst.uniVac500", int'(uni_vacated_space), 500);
    checkOutput("rst.vac200", int'(vacated_space), 200);
    checkOutput("rst.pFlag", int'(parking_is_vacated_space), 1);

    $display("[TB] uni fill at hour 10");
    for (int i = 0; i < 600; i++) applyStimulus("uniFill", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("uniFull.count", int'(uni_parked_car), 500);
    checkOutput("uniFull.vac", int'(uni_vacated_space), 0);
    checkOutput("uniFull.flag", int'(uni_is_vacated_space), 0);

    applyStimulus("uniSwapFull", 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("uniSwapFull.count", int'(uni_parked_car), 500);

    $display("[TB] non-uni fill at hour 10");
    for (int i = 0; i < 250; i++) applyStimulus("nonFill", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("nonFull.count", int'(parked_car), 200);
    checkOutput("nonFull.flag", int'(is_vacated_space), 0);
    checkOutput("lotFull.flag", int'(parking_is_vacated_space), 0);

    $display("[TB] hour stepping");
    setHour(12);
    setHour(13);
    checkOutput("shrink13.uniVac", int'(uni_vacated_space), 0);
    checkOutput("shrink13.count", int'(uni_parked_car), 500);
    setHour(12);
    for (int i = 0; i < 150; i++) applyStimulus("uniLeave", 1'b0, 1'b0, 1'b1, 1'b1);
    setHour(13);
    checkOutput("ramp13.vac", int'(vacated_space), 50);
    setHour(15);
    checkOutput("ramp15.vac", int'(vacated_space), 150);
    checkOutput("ramp15.uniVac", int'(uni_vacated_space), 0);

    $display("[TB] shared window");
    setHour(17);
    for (int i = 0; i < 50; i++) applyStimulus("uniLeave17", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) applyStimulus("nonLeave17", 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("shared.uniVac", int'(uni_vacated_space), 300);
    checkOutput("shared.vac", int'(vacated_space), 300);
    for (int i = 0; i < 100; i++) applyStimulus("nonDrain", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("nonUnderflow", 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("underflow.count", int'(parked_car), 0);
    applyStimulus("uniSwap", 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("uniSwap.count", int'(uni_parked_car), 300);
    applyStimulus("crossSwap", 1'b1, 1'b0, 1'b1, 1'b1);
    setHour(26);
    setHour(3);

    $display("[TB] reset mid-burst");
    for (int i = 0; i < 5; i++) applyStimulus("burst", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    car_entered        = 1'b1;
    is_uni_car_entered = 1'b1;
    rst_n              = 1'b0;
    mUni               = 0;
    mNon               = 0;
    pushExpect();
    @(posedge clk);
    #1;
    compareNext("midReset");
    checkOutput("midReset.uni", int'(uni_parked_car), 0);
    @(negedge clk);
    rst_n       = 1'b1;
    car_entered = 1'b0;
    applyStimulus("postReset", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
